// File: rtl/tv80_pkg.sv
// Shared constants for the TV80 block-instruction register update sequencer:
// register-pair indices, op bit positions and the sequencer state encoding.
package tv80_pkg;

  localparam logic [1:0] BC_PAIR = 2'd0;
  localparam logic [1:0] DE_PAIR = 2'd1;
  localparam logic [1:0] HL_PAIR = 2'd2;

  // op[OP_DEC]: 1 = decrement HL/DE; op[OP_MOVE]: 1 = move (DE is updated too)
  localparam int OP_DEC  = 0;
  localparam int OP_MOVE = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_HL   = 3'd1,
    S_DE   = 3'd2,
    S_BC   = 3'd3,
    S_DONE = 3'd4
  } blk_state_t;

endpackage

// File: rtl/tv80_blkupd_if.sv
// Register-file port A as seen by the block update sequencer: address,
// byte write data/enables out, combinational read data back.
interface tv80_blkupd_if;
  logic [2:0] RegAddr;
  logic [7:0] RegDIH;
  logic [7:0] RegDIL;
  logic       RegWEH;
  logic       RegWEL;
  logic [7:0] RegDOH;
  logic [7:0] RegDOL;

  modport master (output RegAddr, RegDIH, RegDIL, RegWEH, RegWEL,
                  input  RegDOH, RegDOL);
  modport slave  (input  RegAddr, RegDIH, RegDIL, RegWEH, RegWEL,
                  output RegDOH, RegDOL);
endinterface

// File: rtl/tv80_inc16.sv
// 16-bit modulo +/-1 unit; shared by every register-pair update state.
module tv80_inc16 (
  input  logic [15:0] a,
  input  logic        dec,
  output logic [15:0] y
);
  assign y = dec ? (a - 16'd1) : (a + 16'd1);
endmodule

// File: rtl/tv80_blkupd.sv
// Block instruction register-pair sequencer: read-modify-write of HL, DE
// (move ops only) and BC through register-file port A, one pair per cycle.
module tv80_blkupd
  import tv80_pkg::*;
#(
  parameter logic [1:0] BC_IDX = BC_PAIR,
  parameter logic [1:0] DE_IDX = DE_PAIR,
  parameter logic [1:0] HL_IDX = HL_PAIR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        alt,
  output logic        busy,
  output logic        done,
  output logic        bc_nz,
  output logic [15:0] hl_q,
  output logic [15:0] de_q,
  tv80_blkupd_if.master rf
);

  blk_state_t  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        alt_q, alt_d;
  logic        bc_nz_q, bc_nz_d;
  logic [15:0] hl_d, de_d;

  logic [1:0]  pair;
  logic        dir_dec;
  logic        we;
  logic [15:0] rd_val;
  logic [15:0] upd_val;

  assign rd_val = {rf.RegDOH, rf.RegDOL};

  tv80_inc16 u_inc16 (
    .a   (rd_val),
    .dec (dir_dec),
    .y   (upd_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      alt_q   <= 1'b0;
      bc_nz_q <= 1'b0;
      hl_q    <= 16'd0;
      de_q    <= 16'd0;
    end else if (cen) begin
      state_q <= state_d;
      op_q    <= op_d;
      alt_q   <= alt_d;
      bc_nz_q <= bc_nz_d;
      hl_q    <= hl_d;
      de_q    <= de_d;
    end
  end

  // The register file commits the write on the same enabled edge that
  // advances the state, so each update state lasts exactly one enabled cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    alt_d   = alt_q;
    bc_nz_d = bc_nz_q;
    hl_d    = hl_q;
    de_d    = de_q;
    pair    = BC_IDX;
    dir_dec = 1'b1;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          alt_d   = alt;
          state_d = S_HL;
        end
      end
      S_HL: begin
        pair    = HL_IDX;
        dir_dec = op_q[OP_DEC];
        we      = 1'b1;
        hl_d    = rd_val;
        state_d = op_q[OP_MOVE] ? S_DE : S_BC;
      end
      S_DE: begin
        pair    = DE_IDX;
        dir_dec = op_q[OP_DEC];
        we      = 1'b1;
        de_d    = rd_val;
        state_d = S_BC;
      end
      S_BC: begin
        pair    = BC_IDX;
        dir_dec = 1'b1;
        we      = 1'b1;
        bc_nz_d = (upd_val != 16'd0);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf.RegAddr = we ? {alt_q, pair} : 3'd0;
  assign rf.RegDIH  = we ? upd_val[15:8] : 8'd0;
  assign rf.RegDIL  = we ? upd_val[7:0]  : 8'd0;
  assign rf.RegWEH  = we;
  assign rf.RegWEL  = we;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == S_DONE);
  assign bc_nz = bc_nz_q;

endmodule

// File: tb/tb_tv80_blkupd.sv
// Scoreboard bench for tv80_blkupd: a register-file model answers reads,
// a pair-level reference model predicts each block op, a monitor checks at done.
module tb_tv80_blkupd;
  import tv80_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       cen   = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op    = 2'd0;
  logic       alt   = 1'b0;
  logic       busy, done, bc_nz;
  logic [15:0] hl_q, de_q;

  tv80_blkupd_if rf_if ();

  tv80_blkupd dut (
    .clk   (clk),
    .reset (reset),
    .cen   (cen),
    .start (start),
    .op    (op),
    .alt   (alt),
    .busy  (busy),
    .done  (done),
    .bc_nz (bc_nz),
    .hl_q  (hl_q),
    .de_q  (de_q),
    .rf    (rf_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0;
  int stall_req = 0;
  bit rand_cen = 1'b0;

  logic [15:0] rf  [8];   // register file seen by the DUT
  logic [15:0] mrf [8];   // reference model of the same registers
  logic [15:0] last_de = 16'd0;

  typedef struct {
    logic [15:0]      hl;
    logic [15:0]      de;
    logic             bcnz;
    logic             move;
    logic [2:0]       base;
    int               en0;
    logic [7:0][15:0] rf;
  } exp_t;

  exp_t sb[$];
  int   wcnt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_if.RegDOH = rf[rf_if.RegAddr][15:8];
  assign rf_if.RegDOL = rf[rf_if.RegAddr][7:0];

  always @(posedge clk) begin
    if (cen && rf_if.RegWEH) rf[rf_if.RegAddr][15:8] <= rf_if.RegDIH;
    if (cen && rf_if.RegWEL) rf[rf_if.RegAddr][7:0]  <= rf_if.RegDIL;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // cen changes 2 time units after each rising edge, so it is stable across
  // the following negedge (where the monitor samples) and the next posedge.
  initial forever begin
    @(posedge clk);
    #2;
    if (stall_req > 0) begin
      cen = 1'b0;
      stall_req--;
    end else if (rand_cen) begin
      cen = ($urandom_range(0, 3) != 0);
    end else begin
      cen = 1'b1;
    end
  end

  // Monitor: counts committed writes and enabled edges, checks on done.
  initial begin
    logic done_prev;
    exp_t e;
    int   nw;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 8; i++) wcnt[i] = 0;
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          chk("sb_nonempty_at_done", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hl_q", 32'(hl_q), 32'(e.hl));
            chk("de_q", 32'(de_q), 32'(e.de));
            chk("bc_nz", 32'(bc_nz), 32'(e.bcnz));
            chk("latency", 32'(en_cnt - e.en0 + 1), e.move ? 32'd4 : 32'd3);
            chk("wr_hl", 32'(wcnt[e.base + 3'd2]), 32'd1);
            chk("wr_de", 32'(wcnt[e.base + 3'd1]), e.move ? 32'd1 : 32'd0);
            chk("wr_bc", 32'(wcnt[e.base]), 32'd1);
            nw = 0;
            for (int i = 0; i < 8; i++) nw += wcnt[i];
            chk("wr_total", 32'(nw), e.move ? 32'd3 : 32'd2);
            for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), 32'(rf[i]), 32'(e.rf[i]));
            $display("txn op=%0d base=%0d hl_q=%h de_q=%h bc_nz=%0d", {e.move, 1'b0}, e.base, hl_q, de_q, bc_nz);
          end
          for (int i = 0; i < 8; i++) wcnt[i] = 0;
        end
        done_prev = done;
        if (cen && rf_if.RegWEH) wcnt[rf_if.RegAddr]++;
        if (cen) en_cnt++;
      end
    end
  end

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] v);
    rf[idx]  = v;
    mrf[idx] = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // Predicts the pair-level result, issues start, pushes the expectation.
  task automatic run_op(input logic [1:0] o, input logic a, input bit restart_in_hl);
    exp_t e;
    logic [2:0]  b;
    logic [15:0] h, d, c;
    bit acc;
    wait_idle();
    b = {a, 2'b00};
    h = mrf[b + 3'd2];
    d = mrf[b + 3'd1];
    c = mrf[b];
    mrf[b + 3'd2] = o[0] ? h - 16'd1 : h + 16'd1;
    if (o[1]) begin
      mrf[b + 3'd1] = o[0] ? d - 16'd1 : d + 16'd1;
      last_de = d;
    end
    mrf[b] = c - 16'd1;
    e.hl   = h;
    e.de   = last_de;
    e.bcnz = (mrf[b] != 16'd0);
    e.move = o[1];
    e.base = b;
    for (int i = 0; i < 8; i++) e.rf[i] = mrf[i];
    op = o; alt = a; start = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(posedge clk);
      #1;
      if (cen) acc = 1'b1;
    end
    start = 1'b0;
    op  = 2'($urandom);
    alt = 1'($urandom);
    chk("start_accepted", 32'(acc), 32'd1);
    e.en0 = en_cnt;
    sb.push_back(e);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (restart_in_hl) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick16(input int sel);
    case (sel)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] save [8];
    logic [20:0] snap;
    int c0;
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'h1111 * 16'(i + 1));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bc_nz", 32'(bc_nz), 32'd0);
    chk("rst_hl_q", 32'(hl_q), 32'd0);
    chk("rst_de_q", 32'(de_q), 32'd0);
    chk("rst_port", 32'({rf_if.RegAddr, rf_if.RegDIH, rf_if.RegDIL, rf_if.RegWEH, rf_if.RegWEL}), 32'd0);

    // LDI
    set_reg(3'd2, 16'h1000); set_reg(3'd1, 16'h2000); set_reg(3'd0, 16'h0003);
    run_op(2'b10, 1'b0, 1'b0);
    wait_idle();

    // CPD with HL wrap and BC reaching zero
    set_reg(3'd2, 16'h0000); set_reg(3'd0, 16'h0001);
    run_op(2'b01, 1'b0, 1'b0);
    wait_idle();

    // BC' underflow in the alternate set
    set_reg(3'd4, 16'h0000);
    run_op(2'b10, 1'b1, 1'b0);
    wait_idle();

    // reset in S_DE: HL already written, DE/BC untouched
    for (int i = 0; i < 8; i++) save[i] = mrf[i];
    run_op(2'b10, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_mid_in_de", 32'(rf_if.RegAddr), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_we", 32'({rf_if.RegWEH, rf_if.RegWEL}), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_bc_nz", 32'(bc_nz), 32'd0);
    chk("rst_mid_de_q", 32'(de_q), 32'd0);
    void'(sb.pop_back());
    for (int i = 0; i < 8; i++) mrf[i] = save[i];
    mrf[2] = save[2] + 16'd1;
    last_de = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_mid_hl_reg", 32'(rf[2]), 32'(mrf[2]));
    chk("rst_mid_de_reg", 32'(rf[1]), 32'(mrf[1]));
    chk("rst_mid_bc_reg", 32'(rf[0]), 32'(mrf[0]));

    // cen held low for 5 cycles while in S_DE
    run_op(2'b11, 1'b0, 1'b0);
    c0 = cyc;
    @(posedge clk);
    #1;
    chk("cen_in_de", 32'(rf_if.RegAddr), 32'd1);
    snap = {rf_if.RegAddr, rf_if.RegDIH, rf_if.RegDIL, rf_if.RegWEH, rf_if.RegWEL};
    stall_req = 5;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("cen_hold_port", 32'({rf_if.RegAddr, rf_if.RegDIH, rf_if.RegDIL, rf_if.RegWEH, rf_if.RegWEL}), 32'(snap));
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    chk("cen_done_cycle", 32'(cyc - c0), 32'd8);
    wait_idle();

    // second start during S_HL must be ignored
    run_op(2'b00, 1'b0, 1'b1);
    wait_idle();
    repeat (6) @(posedge clk);
    #1;

    // randomized ops with boundary presets and random clock enable
    rand_cen = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic a;
      a = 1'($urandom);
      wait_idle();
      if ($urandom_range(0, 2) == 0) begin
        set_reg({a, 2'd2}, pick16($urandom_range(0, 3)));
        set_reg({a, 2'd1}, pick16($urandom_range(0, 3)));
        set_reg({a, 2'd0}, pick16($urandom_range(0, 3)));
      end
      run_op(2'($urandom), a, 1'($urandom_range(0, 3) == 0));
    end
    wait_idle();
    rand_cen = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
